// File: rtl/inst_line_cache.sv
// rtl/inst_line_cache.sv - direct-mapped instruction cache of 16-byte lines in front of RAM port A
module inst_line_cache #(
   parameter int ADDR_WIDTH  = 17,
   parameter int INDEX_WIDTH = 4,
   parameter int MEM_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  req_valid,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   output logic                  req_ready,
   output logic                  resp_valid,
   output logic [31:0]           resp_inst,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic [127:0]          mem_line
);
   localparam int LINES = 1 << INDEX_WIDTH;
   localparam int TAG_W = ADDR_WIDTH - 4 - INDEX_WIDTH;
   localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LATENCY - 1);

   typedef enum logic [1:0] {IDLE, FILL, RESP} state_t;

   state_t                 state;
   logic [LINES-1:0]       valid_q;
   logic [TAG_W-1:0]       tag_q  [LINES];
   logic [127:0]           data_q [LINES];
   logic [CNT_W-1:0]       cnt;
   logic [1:0]             off_q;
   logic [INDEX_WIDTH-1:0] idx_q;
   logic [TAG_W-1:0]       tag_lq;

   logic [1:0]             req_off;
   logic [INDEX_WIDTH-1:0] req_idx;
   logic [TAG_W-1:0]       req_tag;
   logic                   req_hit;
   logic                   accept;
   logic                   fill_done;
   logic                   unused_bits;

   assign req_off     = req_addr[3:2];
   assign req_idx     = req_addr[4+INDEX_WIDTH-1:4];
   assign req_tag     = req_addr[ADDR_WIDTH-1:4+INDEX_WIDTH];
   assign unused_bits = ^req_addr[1:0];
   assign req_hit     = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
   assign accept      = (state == IDLE) && req_valid && !flush;
   assign fill_done   = (state == FILL) && (cnt == CNT_LAST) && !flush;

   // Byte k of a line sits at [127-8k -: 8]; the word is assembled little-endian.
   function automatic logic [31:0] extract(input logic [127:0] line, input logic [1:0] off);
      logic [31:0] w;
      int          o;
      o = int'(off);
      w = '0;
      for (int j = 0; j < 4; j++) begin
         w[8*j +: 8] = line[127 - 8*(4*o + j) -: 8];
      end
      return w;
   endfunction

   always_ff @(posedge clk) begin
      if (!rst && fill_done) begin
         data_q[idx_q] <= mem_line;
         tag_q[idx_q]  <= tag_lq;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         valid_q    <= '0;
         cnt        <= '0;
         resp_valid <= 1'b0;
         resp_inst  <= '0;
         mem_addr   <= '0;
         req_ready  <= 1'b1;
         off_q      <= '0;
         idx_q      <= '0;
         tag_lq     <= '0;
      end else begin
         resp_valid <= 1'b0;
         if (flush) valid_q <= '0;
         case (state)
            IDLE: begin
               if (accept) begin
                  off_q     <= req_off;
                  idx_q     <= req_idx;
                  tag_lq    <= req_tag;
                  req_ready <= 1'b0;
                  if (req_hit) begin
                     resp_inst  <= extract(data_q[req_idx], req_off);
                     resp_valid <= 1'b1;
                     state      <= RESP;
                  end else begin
                     mem_addr <= {req_tag, req_idx, 4'b0000};
                     cnt      <= '0;
                     state    <= FILL;
                  end
               end
            end
            FILL: begin
               // A flush mid-fill drops the line entirely: no write, no response.
               if (flush) begin
                  state     <= IDLE;
                  req_ready <= 1'b1;
               end else if (cnt == CNT_LAST) begin
                  valid_q[idx_q] <= 1'b1;
                  resp_inst      <= extract(mem_line, off_q);
                  resp_valid     <= 1'b1;
                  state          <= RESP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            RESP: begin
               state     <= IDLE;
               req_ready <= 1'b1;
            end
            default: begin
               state     <= IDLE;
               req_ready <= 1'b1;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_inst_line_cache.sv
// tb/tb_inst_line_cache.sv - scoreboard bench driving latency-1 and latency-3 caches in lockstep
module tb_inst_line_cache;
   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        req_valid;
   logic [16:0] req_addr;

   logic        rdy0, rdy1, rv0, rv1;
   logic [31:0] ri0, ri1;
   logic [16:0] ma0, ma1;
   logic [127:0] ml0, ml1;

   logic        rdy [2];
   logic        rv  [2];
   logic [31:0] ri  [2];
   logic [16:0] ma  [2];
   int          lat_mem [2];

   assign rdy[0] = rdy0; assign rdy[1] = rdy1;
   assign rv[0]  = rv0;  assign rv[1]  = rv1;
   assign ri[0]  = ri0;  assign ri[1]  = ri1;
   assign ma[0]  = ma0;  assign ma[1]  = ma1;

   always #5 clk = ~clk;

   inst_line_cache #(.ADDR_WIDTH(17), .INDEX_WIDTH(4), .MEM_LATENCY(1)) dut1 (
      .clk(clk), .rst(rst), .flush(flush), .req_valid(req_valid), .req_addr(req_addr),
      .req_ready(rdy0), .resp_valid(rv0), .resp_inst(ri0), .mem_addr(ma0), .mem_line(ml0));

   inst_line_cache #(.ADDR_WIDTH(17), .INDEX_WIDTH(4), .MEM_LATENCY(3)) dut3 (
      .clk(clk), .rst(rst), .flush(flush), .req_valid(req_valid), .req_addr(req_addr),
      .req_ready(rdy1), .resp_valid(rv1), .resp_inst(ri1), .mem_addr(ma1), .mem_line(ml1));

   logic [7:0] ram [0:131071];

   always_comb begin
      ml0 = '0;
      ml1 = '0;
      for (int k = 0; k < 16; k++) begin
         ml0[127-8*k -: 8] = ram[ma0 + 17'(k)];
         ml1[127-8*k -: 8] = ram[ma1 + 17'(k)];
      end
   end

   typedef struct {
      logic [31:0] inst;
      int          due;
      bit          miss;
   } exp_t;

   exp_t        q0[$];
   exp_t        q1[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          fillcnt [2];
   logic [16:0] cur_line = '0;

   // Reference cache state: which line address each index currently holds.
   bit          mvalid [16];
   logic [8:0]  mtag   [16];

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] ref_word(input logic [16:0] a);
      logic [16:0] b;
      b = {a[16:2], 2'b00};
      return {ram[b + 17'd3], ram[b + 17'd2], ram[b + 17'd1], ram[b]};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic mon(input int d);
      exp_t e;
      bit   have;
      if (rv[d]) begin
         have = 1'b0;
         if (d == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
         if (d == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
         if (!have) begin
            checks++; errors++;
            $display("FAIL unexpected_resp dut%0d: got resp_valid=1 inst %h, required no response", d, ri[d]);
         end else begin
            chk($sformatf("resp_inst dut%0d", d), ri[d], e.inst);
            chk($sformatf("resp_cycle dut%0d", d), cyc, e.due);
            if (e.miss) chk($sformatf("fill_cycles dut%0d", d), fillcnt[d], lat_mem[d]);
         end
         fillcnt[d] = 0;
      end else if (!rdy[d]) begin
         fillcnt[d]++;
         chk($sformatf("mem_addr dut%0d", d), {15'd0, ma[d]}, {15'd0, cur_line});
      end else begin
         fillcnt[d] = 0;
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         mon(0);
         mon(1);
      end
   end

   task automatic finish_run();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   endtask

   task automatic wait_ready();
      int t;
      t = 0;
      while (!(rdy[0] && rdy[1])) begin
         req_valid = !rdy[0] && !rdy[1];
         req_addr  = 17'($urandom);
         flush     = 1'b0;
         @(negedge clk);
         t++;
         if (t > 100) begin
            checks++; errors++;
            $display("FAIL ready_timeout: got req_ready=%b/%b after %0d cycles, required 1/1", rdy[0], rdy[1], t);
            finish_run();
         end
      end
      req_valid = 1'b0;
   endtask

   // fm: 0 plain fetch, 1 flush raised with the request, 2 flush one cycle after accept.
   task automatic issue(input logic [16:0] a, input int fm);
      int         n;
      bit         hit;
      logic [3:0] idx;
      logic [8:0] tg;
      exp_t       e;
      wait_ready();
      idx = a[7:4];
      tg  = a[16:8];
      req_valid = 1'b1;
      req_addr  = a;
      flush     = (fm == 1);
      if (fm == 1) begin
         @(negedge clk);
         req_valid = 1'b0;
         flush     = 1'b0;
         for (int i = 0; i < 16; i++) mvalid[i] = 1'b0;
         return;
      end
      n   = cyc;
      hit = mvalid[idx] && (mtag[idx] == tg);
      cur_line = {a[16:4], 4'b0000};
      if (hit || fm != 2) begin
         e.inst = ref_word(a);
         e.miss = !hit;
         e.due  = n + (hit ? 1 : 1 + lat_mem[0]);
         q0.push_back(e);
         e.due  = n + (hit ? 1 : 1 + lat_mem[1]);
         q1.push_back(e);
      end
      if (!hit && fm != 2) begin
         mvalid[idx] = 1'b1;
         mtag[idx]   = tg;
      end
      @(negedge clk);
      flush     = (fm == 2);
      req_valid = 1'b1;
      req_addr  = 17'($urandom);
      if (fm == 2) for (int i = 0; i < 16; i++) mvalid[i] = 1'b0;
      @(negedge clk);
      flush = 1'b0;
   endtask

   initial begin
      logic [8:0]  tg;
      logic [16:0] a;
      int          r;
      lat_mem[0] = 1;
      lat_mem[1] = 3;
      fillcnt[0] = 0;
      fillcnt[1] = 0;
      for (int i = 0; i < 131072; i++) ram[i] = 8'($urandom);
      ram[0] = 8'h13; ram[1] = 8'h00; ram[2] = 8'h00; ram[3] = 8'h00;
      for (int i = 0; i < 16; i++) begin mvalid[i] = 1'b0; mtag[i] = '0; end
      rst = 1'b1; flush = 1'b0; req_valid = 1'b0; req_addr = '0;
      repeat (3) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("reset req_ready dut%0d", d), {31'd0, rdy[d]}, 32'd1);
         chk($sformatf("reset resp_valid dut%0d", d), {31'd0, rv[d]}, 32'd0);
         chk($sformatf("reset resp_inst dut%0d", d), ri[d], 32'd0);
         chk($sformatf("reset mem_addr dut%0d", d), {15'd0, ma[d]}, 32'd0);
      end
      rst = 1'b0;
      @(negedge clk);

      issue(17'h00000, 0);
      issue(17'h00004, 0);
      issue(17'h00008, 0);
      issue(17'h0000C, 0);
      issue(17'h00100, 0);
      issue(17'h00000, 0);
      issue(17'h00040, 2);
      issue(17'h00040, 0);
      issue(17'h1FFF0, 0);
      issue(17'h1FFF7, 0);
      issue(17'h00044, 1);
      issue(17'h00044, 0);

      for (int i = 0; i < 300; i++) begin
         r  = $urandom_range(0, 3);
         tg = (r == 3) ? 9'h1FF : 9'(r);
         a  = {tg, 4'($urandom), 2'($urandom), 2'($urandom)};
         r  = $urandom_range(0, 19);
         issue(a, (r == 0) ? 1 : (r == 1) ? 2 : 0);
      end

      // Reset in the middle of a fill must abort it and leave every line invalid.
      issue(17'h00200, 1);
      wait_ready();
      cur_line  = 17'h00200;
      req_valid = 1'b1;
      req_addr  = 17'h00200;
      @(negedge clk);
      req_valid = 1'b0;
      rst       = 1'b1;
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("midfill reset req_ready dut%0d", d), {31'd0, rdy[d]}, 32'd1);
         chk($sformatf("midfill reset resp_valid dut%0d", d), {31'd0, rv[d]}, 32'd0);
         chk($sformatf("midfill reset mem_addr dut%0d", d), {15'd0, ma[d]}, 32'd0);
      end
      rst = 1'b0;
      for (int i = 0; i < 16; i++) mvalid[i] = 1'b0;
      @(negedge clk);
      issue(17'h00200, 0);
      issue(17'h00204, 0);

      wait_ready();
      repeat (5) @(negedge clk);
      chk("q0_drained", q0.size(), 32'd0);
      chk("q1_drained", q1.size(), 32'd0);
      finish_run();
   end

   initial begin
      #2000000;
      checks++; errors++;
      $display("FAIL global_timeout: got simulation still running at %0t, required completion", $time);
      finish_run();
   end
endmodule
